// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer: FSM state encoding, push word order
// and the reset / vector defaults.
package stack_sequencer_pkg;

    localparam logic [15:0] SP_INIT_DEF    = 16'h07FF;
    localparam logic [15:0] INT_VECTOR_DEF = 16'h0000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH_HI  = 3'd1;
    localparam logic [2:0] ST_PUSH_LO  = 3'd2;
    localparam logic [2:0] ST_PUSH_FLG = 3'd3;
    localparam logic [2:0] ST_VEC      = 3'd4;
    localparam logic [2:0] ST_POP_FLG  = 3'd5;
    localparam logic [2:0] ST_POP_LO   = 3'd6;
    localparam logic [2:0] ST_POP_HI   = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PUSH_HI  = ST_PUSH_HI,
        PUSH_LO  = ST_PUSH_LO,
        PUSH_FLG = ST_PUSH_FLG,
        VEC      = ST_VEC,
        POP_FLG  = ST_POP_FLG,
        POP_LO   = ST_POP_LO,
        POP_HI   = ST_POP_HI
    } state_t;

    // The high half of a PC goes onto the stack first, so it is popped last.
    localparam logic WORD_HI = 1'b1;
    localparam logic WORD_LO = 1'b0;

    function automatic logic [15:0] pc_word(input logic [31:0] pc, input logic hi);
        return hi ? pc[31:16] : pc[15:0];
    endfunction

endpackage

// File: rtl/stack_sequencer_stack_pointer.sv
// Stack pointer register with increment / decrement / hold, 16-bit modulo.
// Latency: new value visible the cycle after inc/dec.
// Backpressure: none; inc wins if both strobes are raised.
module stack_pointer
    import stack_sequencer_pkg::*;
#(
    parameter logic [15:0] SP_INIT = SP_INIT_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] sp,
    output logic [15:0] sp_plus1
);

    assign sp_plus1 = sp + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sp <= SP_INIT;
        end else if (inc) begin
            sp <= sp_plus1;
        end else if (dec) begin
            sp <= sp - 16'd1;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Owns SP and the data-memory port: single-word PUSH/POP pass through, PC/flag saves become word sequences.
// Latency: pass-through same cycle; CALL/RET 3 cycles, RTI 4, interrupt entry 5 (incl. accept cycle).
// Backpressure: o_stall holds the pipeline from the accept cycle until the last sequence state.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [15:0] SP_INIT    = SP_INIT_DEF,
    parameter logic [15:0] INT_VECTOR = INT_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_push_pc,
    input  logic        i_pop_pc,
    input  logic        i_rti,
    input  logic        i_interrupt,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_flags,
    input  logic        i_pipe_mem_read,
    input  logic        i_pipe_mem_write,
    input  logic        i_pipe_stack_op,
    input  logic [15:0] i_pipe_address,
    input  logic [15:0] i_pipe_wdata,
    input  logic [15:0] i_mem_rdata,
    output logic [15:0] o_mem_address,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_stall,
    output logic        o_pc_valid,
    output logic [31:0] o_pc_new,
    output logic        o_flags_valid,
    output logic [2:0]  o_flags,
    output logic [15:0] o_sp
);

    state_t      state_q, state_d;
    logic        seq_is_int_q, seq_is_int_d;
    logic        int_pending_q;
    logic        int_clr;
    logic        accept;
    logic [31:0] pc_save_q;
    logic [2:0]  flg_save_q;
    logic [15:0] lo_reg_q;
    logic        sp_inc, sp_dec;
    logic [15:0] sp, sp_plus1;

    stack_pointer #(.SP_INIT(SP_INIT)) u_sp (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp),
        .sp_plus1 (sp_plus1)
    );

    assign o_sp = sp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            seq_is_int_q  <= 1'b0;
            int_pending_q <= 1'b0;
            pc_save_q     <= 32'h0;
            flg_save_q    <= 3'h0;
            lo_reg_q      <= 16'h0;
        end else begin
            state_q      <= state_d;
            seq_is_int_q <= seq_is_int_d;
            // A new request arriving in the same cycle as acceptance must not be lost.
            if (i_interrupt) begin
                int_pending_q <= 1'b1;
            end else if (int_clr) begin
                int_pending_q <= 1'b0;
            end
            if (accept) begin
                pc_save_q  <= i_pc;
                flg_save_q <= i_flags;
            end
            if (state_q == POP_LO) begin
                lo_reg_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        seq_is_int_d  = seq_is_int_q;
        accept        = 1'b0;
        int_clr       = 1'b0;
        sp_inc        = 1'b0;
        sp_dec        = 1'b0;
        o_mem_address = 16'h0;
        o_mem_wdata   = 16'h0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_stall       = 1'b0;
        o_pc_valid    = 1'b0;
        o_pc_new      = 32'h0;
        o_flags_valid = 1'b0;
        o_flags       = 3'h0;

        case (state_q)
            IDLE: begin
                if (i_push_pc) begin
                    state_d      = PUSH_HI;
                    seq_is_int_d = 1'b0;
                    accept       = 1'b1;
                end else if (i_pop_pc) begin
                    state_d = POP_LO;
                    accept  = 1'b1;
                end else if (i_rti) begin
                    state_d = POP_FLG;
                    accept  = 1'b1;
                end else if (int_pending_q) begin
                    state_d      = PUSH_HI;
                    seq_is_int_d = 1'b1;
                    accept       = 1'b1;
                    int_clr      = 1'b1;
                end else begin
                    o_mem_read  = i_pipe_mem_read;
                    o_mem_write = i_pipe_mem_write;
                    o_mem_wdata = i_pipe_wdata;
                    if (i_pipe_stack_op) begin
                        o_mem_address = i_pipe_mem_write ? sp : sp_plus1;
                        sp_dec        = i_pipe_mem_write;
                        sp_inc        = i_pipe_mem_read;
                    end else begin
                        o_mem_address = i_pipe_address;
                    end
                end
                o_stall = accept;
            end
            PUSH_HI: begin
                o_mem_write   = 1'b1;
                o_mem_address = sp;
                o_mem_wdata   = pc_word(pc_save_q, WORD_HI);
                sp_dec        = 1'b1;
                o_stall       = 1'b1;
                state_d       = PUSH_LO;
            end
            PUSH_LO: begin
                o_mem_write   = 1'b1;
                o_mem_address = sp;
                o_mem_wdata   = pc_word(pc_save_q, WORD_LO);
                sp_dec        = 1'b1;
                o_stall       = seq_is_int_q;
                state_d       = seq_is_int_q ? PUSH_FLG : IDLE;
            end
            PUSH_FLG: begin
                o_mem_write   = 1'b1;
                o_mem_address = sp;
                o_mem_wdata   = {13'b0, flg_save_q};
                sp_dec        = 1'b1;
                o_stall       = 1'b1;
                state_d       = VEC;
            end
            VEC: begin
                o_mem_read    = 1'b1;
                o_mem_address = INT_VECTOR;
                o_pc_new      = {16'b0, i_mem_rdata};
                o_pc_valid    = 1'b1;
                state_d       = IDLE;
            end
            POP_FLG: begin
                o_mem_read    = 1'b1;
                o_mem_address = sp_plus1;
                sp_inc        = 1'b1;
                o_flags       = i_mem_rdata[2:0];
                o_flags_valid = 1'b1;
                o_stall       = 1'b1;
                state_d       = POP_LO;
            end
            POP_LO: begin
                o_mem_read    = 1'b1;
                o_mem_address = sp_plus1;
                sp_inc        = 1'b1;
                o_stall       = 1'b1;
                state_d       = POP_HI;
            end
            POP_HI: begin
                o_mem_read    = 1'b1;
                o_mem_address = sp_plus1;
                sp_inc        = 1'b1;
                o_pc_new      = {i_mem_rdata, lo_reg_q};
                o_pc_valid    = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed scenarios plus random traffic against a
// transaction-level stack/memory model.
module tb_stack_sequencer;

    localparam logic [15:0] SP_INIT    = 16'h07FF;
    localparam logic [15:0] INT_VECTOR = 16'h0000;
    localparam int K_CALL = 0, K_RET = 1, K_RTI = 2, K_INT = 3;
    localparam int P_PUSH = 0, P_POP = 1, P_WR = 2, P_RD = 3;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_push_pc, i_pop_pc, i_rti, i_interrupt;
    logic [31:0] i_pc;
    logic [2:0]  i_flags;
    logic        i_pipe_mem_read, i_pipe_mem_write, i_pipe_stack_op;
    logic [15:0] i_pipe_address, i_pipe_wdata;
    logic [15:0] i_mem_rdata;
    logic [15:0] o_mem_address, o_mem_wdata;
    logic        o_mem_read, o_mem_write, o_stall, o_pc_valid, o_flags_valid;
    logic [31:0] o_pc_new;
    logic [2:0]  o_flags;
    logic [15:0] o_sp;

    logic [15:0] dmem    [0:65535] = '{default: 16'h0000};
    logic [15:0] ref_mem [0:65535] = '{default: 16'h0000};
    logic [15:0] ref_sp;
    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    stack_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_push_pc(i_push_pc), .i_pop_pc(i_pop_pc), .i_rti(i_rti), .i_interrupt(i_interrupt),
        .i_pc(i_pc), .i_flags(i_flags),
        .i_pipe_mem_read(i_pipe_mem_read), .i_pipe_mem_write(i_pipe_mem_write),
        .i_pipe_stack_op(i_pipe_stack_op), .i_pipe_address(i_pipe_address),
        .i_pipe_wdata(i_pipe_wdata), .i_mem_rdata(i_mem_rdata),
        .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_stall(o_stall),
        .o_pc_valid(o_pc_valid), .o_pc_new(o_pc_new),
        .o_flags_valid(o_flags_valid), .o_flags(o_flags), .o_sp(o_sp)
    );

    // Data memory: asynchronous read, write on the rising edge.
    assign i_mem_rdata = dmem[o_mem_address];
    always @(posedge i_clk) begin
        if (o_mem_write) dmem[o_mem_address] <= o_mem_wdata;
    end

    always @(posedge i_clk) begin
        assert (!(i_pipe_stack_op && i_pipe_mem_read && i_pipe_mem_write))
            else $error("illegal stack read+write from pipeline");
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_push_pc = 0; i_pop_pc = 0; i_rti = 0; i_interrupt = 0;
        i_pipe_mem_read = 0; i_pipe_mem_write = 0; i_pipe_stack_op = 0;
        i_pipe_address = 16'h0; i_pipe_wdata = 16'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        i_reset = 1;
        next_cycle();
        next_cycle();
        i_reset = 0;
        ref_sp = SP_INIT;
    endtask

    task automatic pipe_op(input int kind, input logic [15:0] addr, input logic [15:0] data);
        logic [15:0] up;
        up = ref_sp + 16'd1;
        idle_inputs();
        i_pipe_address = addr;
        i_pipe_wdata   = data;
        i_pipe_stack_op  = (kind == P_PUSH || kind == P_POP);
        i_pipe_mem_write = (kind == P_PUSH || kind == P_WR);
        i_pipe_mem_read  = (kind == P_POP || kind == P_RD);
        @(negedge i_clk);
        check_eq("pipe_stall", o_stall, 0);
        case (kind)
            P_PUSH: begin
                check_eq("push_addr", o_mem_address, ref_sp);
                check_eq("push_wr", {o_mem_write, o_mem_wdata}, {1'b1, data});
                ref_mem[ref_sp] = data;
                ref_sp = ref_sp - 16'd1;
            end
            P_POP: begin
                check_eq("pop_addr", o_mem_address, up);
                check_eq("pop_rd", {o_mem_read, o_mem_write, i_mem_rdata}, {2'b10, ref_mem[up]});
                ref_sp = up;
            end
            P_WR: begin
                check_eq("wr_port", {o_mem_write, o_mem_address, o_mem_wdata}, {1'b1, addr, data});
                ref_mem[addr] = data;
            end
            default: begin
                check_eq("rd_port", {o_mem_read, o_mem_address, i_mem_rdata}, {1'b1, addr, ref_mem[addr]});
            end
        endcase
        next_cycle();
        idle_inputs();
        check_eq("pipe_sp", o_sp, ref_sp);
    endtask

    // One whole stack sequence; pend: interrupt already pending, irq_mid: pulse an interrupt mid-sequence.
    task automatic seq_op(input int kind, input logic [31:0] pc, input logic [2:0] flg,
                          input bit pend, input bit irq_mid);
        logic [15:0] sp0, a1, a2, a3;
        logic [31:0] exp_wr[$], got_wr[$];
        logic [31:0] exp_pc, got_pc;
        logic [2:0]  exp_flg, got_flg;
        int exp_stalls, exp_pc_cyc, exp_fl, stalls, pc_cyc, n_pc, n_fl;
        bit done;
        sp0 = ref_sp; a1 = sp0 + 16'd1; a2 = sp0 + 16'd2; a3 = sp0 + 16'd3;
        exp_pc = 32'h0; exp_flg = 3'h0; exp_fl = 0; exp_pc_cyc = -1;
        got_pc = 32'h0; got_flg = 3'h0;
        case (kind)
            K_CALL: begin
                exp_wr.push_back({sp0, pc[31:16]});
                exp_wr.push_back({sp0 - 16'd1, pc[15:0]});
                exp_stalls = 2;
                ref_sp = sp0 - 16'd2;
            end
            K_INT: begin
                exp_wr.push_back({sp0, pc[31:16]});
                exp_wr.push_back({sp0 - 16'd1, pc[15:0]});
                exp_wr.push_back({sp0 - 16'd2, 13'b0, flg});
                exp_stalls = 4;
                exp_pc_cyc = 4;
                ref_sp = sp0 - 16'd3;
            end
            K_RET: begin
                exp_pc = {ref_mem[a2], ref_mem[a1]};
                exp_stalls = 2;
                exp_pc_cyc = 2;
                ref_sp = a2;
            end
            default: begin
                exp_flg = ref_mem[a1][2:0];
                exp_fl = 1;
                exp_pc = {ref_mem[a3], ref_mem[a2]};
                exp_stalls = 3;
                exp_pc_cyc = 3;
                ref_sp = a3;
            end
        endcase
        foreach (exp_wr[i]) ref_mem[exp_wr[i][31:16]] = exp_wr[i][15:0];
        if (kind == K_INT) exp_pc = {16'h0, ref_mem[INT_VECTOR]};

        idle_inputs();
        if (kind == K_INT && !pend) begin
            i_interrupt = 1;
            @(negedge i_clk);
            check_eq("irq_pulse_stall", o_stall, 0);
            next_cycle();
            i_interrupt = 0;
        end
        i_pc = pc; i_flags = flg;
        i_push_pc = (kind == K_CALL);
        i_pop_pc  = (kind == K_RET);
        i_rti     = (kind == K_RTI);
        done = 0; stalls = 0; pc_cyc = -1; n_pc = 0; n_fl = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge i_clk);
            if (c == 0) check_eq("accept_nomem", {o_mem_read, o_mem_write}, 2'b00);
            if (o_stall) stalls++; else done = 1;
            if (o_pc_valid) begin n_pc++; pc_cyc = c; got_pc = o_pc_new; end
            if (o_flags_valid) begin n_fl++; got_flg = o_flags; end
            if (o_mem_write) got_wr.push_back({o_mem_address, o_mem_wdata});
            next_cycle();
            if (c == 0) begin
                i_push_pc = 0; i_pop_pc = 0; i_rti = 0;
                i_pc = $urandom; i_flags = 3'($urandom);
            end
            i_interrupt = irq_mid && (c == 0);
        end
        i_interrupt = 0;
        check_eq("seq_done", done, 1);
        check_eq("seq_stalls", stalls, exp_stalls);
        check_eq("seq_pc_pulses", n_pc, (exp_pc_cyc < 0) ? 0 : 1);
        if (exp_pc_cyc >= 0) begin
            check_eq("seq_pc_cycle", pc_cyc, exp_pc_cyc);
            check_eq("seq_pc_new", got_pc, exp_pc);
        end
        check_eq("seq_flag_pulses", n_fl, exp_fl);
        if (exp_fl != 0) check_eq("seq_flags", got_flg, exp_flg);
        check_eq("seq_nwrites", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check_eq("seq_write", got_wr[i], exp_wr[i]);
        check_eq("seq_sp", o_sp, ref_sp);
    endtask

    initial begin
        int mism;
        i_pc = 32'h0; i_flags = 3'h0;
        do_reset();
        @(negedge i_clk);
        check_eq("rst_sp", o_sp, 16'h07FF);
        check_eq("rst_outs", {o_stall, o_mem_write, o_mem_read, o_pc_valid, o_flags_valid}, 5'b0);
        next_cycle();

        seq_op(K_CALL, 32'h0001_2345, 3'b000, 0, 0);
        check_eq("call_mem_hi", dmem[16'h07FF], 16'h0001);
        check_eq("call_mem_lo", dmem[16'h07FE], 16'h2345);
        check_eq("call_sp", o_sp, 16'h07FD);
        seq_op(K_RET, 32'h0, 3'b000, 0, 0);
        check_eq("ret_sp", o_sp, 16'h07FF);

        pipe_op(P_WR, 16'h0000, 16'h0040);
        seq_op(K_INT, 32'hDEAD_0010, 3'b101, 0, 0);
        check_eq("int_flag_word", dmem[16'h07FD], 16'h0005);
        seq_op(K_RTI, 32'h0, 3'b000, 0, 0);
        check_eq("rti_sp", o_sp, 16'h07FF);

        seq_op(K_CALL, 32'h0000_1111, 3'b000, 0, 1);
        seq_op(K_INT, 32'h0000_2222, 3'b011, 1, 0);
        seq_op(K_RTI, 32'h0, 3'b000, 0, 0);
        seq_op(K_RET, 32'h0, 3'b000, 0, 0);

        pipe_op(P_PUSH, 16'h0, 16'hBEEF);
        check_eq("push_mem", dmem[16'h07FF], 16'hBEEF);
        pipe_op(P_POP, 16'h0, 16'h0);
        check_eq("pop_sp", o_sp, 16'h07FF);

        // Reset lands while in PUSH_LO; both partial writes stay in memory.
        idle_inputs();
        i_pc = 32'hA5A5_5A5A; i_push_pc = 1;
        next_cycle();
        i_push_pc = 0;
        next_cycle();
        i_reset = 1;
        next_cycle();
        i_reset = 0;
        ref_mem[16'h07FF] = 16'hA5A5;
        ref_mem[16'h07FE] = 16'h5A5A;
        ref_sp = SP_INIT;
        @(negedge i_clk);
        check_eq("midrst_sp", o_sp, 16'h07FF);
        check_eq("midrst_outs", {o_stall, o_mem_write, o_pc_valid}, 3'b000);
        next_cycle();

        // Walk SP through the 0000 -> FFFF wrap and back.
        for (int i = 0; i < 16'h0800; i++) pipe_op(P_PUSH, 16'h0, 16'($urandom));
        check_eq("wrap_sp", o_sp, 16'hFFFF);
        pipe_op(P_POP, 16'h0, 16'h0);
        check_eq("unwrap_sp", o_sp, 16'h0000);
        do_reset();
        pipe_op(P_WR, INT_VECTOR, 16'h0123);

        for (int n = 0; n < 300; n++) begin
            int r;
            bit mid;
            r = $urandom_range(0, 7);
            case (r)
                0: begin
                    mid = ($urandom_range(0, 3) == 0);
                    seq_op(K_CALL, $urandom, 3'h0, 0, mid);
                    if (mid) seq_op(K_INT, $urandom, 3'($urandom), 1, 0);
                end
                1: seq_op(K_RET, 32'h0, 3'h0, 0, 0);
                2: seq_op(K_RTI, 32'h0, 3'h0, 0, 0);
                3: seq_op(K_INT, $urandom, 3'($urandom), 0, 0);
                4: pipe_op(P_PUSH, 16'h0, 16'($urandom));
                5: pipe_op(P_POP, 16'h0, 16'h0);
                6: pipe_op(P_WR, 16'($urandom_range(0, 7)), 16'($urandom));
                default: pipe_op(P_RD, 16'($urandom_range(0, 7)), 16'h0);
            endcase
        end

        mism = 0;
        for (int a = 0; a < 65536; a++) if (dmem[a] !== ref_mem[a]) mism++;
        check_eq("mem_sweep", mism, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
